vu_bus_master: RTL and testbench

- Initiator side of the Vector-06C expansion (ВУ) bus.
- Turns single memory or I/O requests from an internal client (board self-test, loopback bench, emulated host) into complete bus cycles:
  - status-word strobe;
  - multiplexed RAS/CAS address on ШАП, or I/O address on ШАВВ;
  - read/write strobe.
- Samples ~БЛК and ШД to return read data.
- Sits between the client and the external bus pins, or directly faces the board's bus responder in loopback.

---
 rtl/vu_bus_master.sv | 218 +++++++++++++++++++++
 tb/tb_vu_bus_master.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/vu_bus_master.sv
// Initiator for the Vector-06C expansion bus: turns one client request into a
// full status / address / strobe cycle and samples the responder's read data.
module vu_bus_master #(
    parameter int T_STATUS = 2,
    parameter int T_ADDR   = 2,
    parameter int T_STROBE = 4
) (
    input  logic        clk_cpu,
    input  logic        sys_reset,
    input  logic        req,
    input  logic [1:0]  op,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic        stack,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rdata,
    output logic        responded,
    output logic [7:0]  vu_shap_n,
    output logic [7:0]  vu_shavv_n,
    output logic        vu_ras_n,
    output logic        vu_cas_n,
    output logic        vu_memrd_n,
    output logic        vu_memwr_n,
    output logic        vu_iord_n,
    output logic        vu_iowr_n,
    output logic        vu_strob_sost,
    output logic [7:0]  vu_shd_o,
    output logic        vu_shd_oe,
    input  logic [7:0]  vu_shd_i,
    input  logic        vu_blk_n
);

    localparam logic [1:0] OP_MEMRD = 2'b00;
    localparam logic [1:0] OP_MEMWR = 2'b01;
    localparam logic [1:0] OP_IORD  = 2'b10;
    localparam logic [1:0] OP_IOWR  = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_STAT_SETUP, S_STAT_PULSE, S_STAT_HOLD, S_ROW, S_RAS,
        S_COL_SETUP, S_CAS, S_IOADDR, S_STROBE, S_END
    } state_t;

    typedef struct packed {
        logic [7:0] shap_n;
        logic [7:0] shavv_n;
        logic       ras_n;
        logic       cas_n;
        logic       memrd_n;
        logic       memwr_n;
        logic       iord_n;
        logic       iowr_n;
        logic       strob_sost;
        logic [7:0] shd_o;
        logic       shd_oe;
        logic       busy;
        logic       done;
    } pins_t;

    localparam pins_t PINS_IDLE = '{
        shap_n: 8'hFF, shavv_n: 8'hFF, ras_n: 1'b1, cas_n: 1'b1,
        memrd_n: 1'b1, memwr_n: 1'b1, iord_n: 1'b1, iowr_n: 1'b1,
        strob_sost: 1'b0, shd_o: 8'h00, shd_oe: 1'b0, busy: 1'b0, done: 1'b0
    };

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    pins_t       pins, pins_n;
    logic [1:0]  op_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic        stack_q;

    // Client fields seen by the decode: live inputs on the accepting edge.
    logic [1:0]  op_s;
    logic [15:0] addr_s;
    logic [7:0]  wdata_s;
    logic        stack_s;
    logic [7:0]  status_s;

    function automatic logic [7:0] phase_len(state_t s);
        case (s)
            S_STAT_PULSE:                  return 8'(T_STATUS - 1);
            S_ROW, S_RAS, S_CAS, S_IOADDR: return 8'(T_ADDR - 1);
            S_STROBE:                      return 8'(T_STROBE - 1);
            default:                       return 8'd0;
        endcase
    endfunction

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (state == S_IDLE) begin
            if (req) state_n = S_STAT_SETUP;
        end else if (cnt != 8'd0) begin
            cnt_n = cnt - 8'd1;
        end else begin
            case (state)
                S_STAT_SETUP: state_n = S_STAT_PULSE;
                S_STAT_PULSE: state_n = S_STAT_HOLD;
                S_STAT_HOLD:  state_n = op_q[1] ? S_IOADDR : S_ROW;
                S_ROW:        state_n = S_RAS;
                S_RAS:        state_n = S_COL_SETUP;
                S_COL_SETUP:  state_n = S_CAS;
                S_CAS:        state_n = S_STROBE;
                S_IOADDR:     state_n = S_STROBE;
                S_STROBE:     state_n = S_END;
                default:      state_n = S_IDLE;
            endcase
            cnt_n = phase_len(state_n);
        end
    end

    always_comb begin
        op_s     = (state == S_IDLE) ? op    : op_q;
        addr_s   = (state == S_IDLE) ? addr  : addr_q;
        wdata_s  = (state == S_IDLE) ? wdata : wdata_q;
        stack_s  = (state == S_IDLE) ? stack : stack_q;
        status_s = {op_s == OP_MEMRD, op_s == OP_IORD, 1'b0, op_s == OP_IOWR,
                    1'b0, stack_s, ~op_s[0], 1'b0};
    end

    // Pins are decoded from the next state and registered, so they never glitch.
    always_comb begin
        pins_n      = PINS_IDLE;
        pins_n.busy = (state_n != S_IDLE);
        pins_n.done = (state_n == S_END);
        case (state_n)
            S_STAT_SETUP, S_STAT_HOLD: begin
                pins_n.shd_oe = 1'b1;
                pins_n.shd_o  = status_s;
            end
            S_STAT_PULSE: begin
                pins_n.shd_oe     = 1'b1;
                pins_n.shd_o      = status_s;
                pins_n.strob_sost = 1'b1;
            end
            S_ROW: pins_n.shap_n = ~addr_s[7:0];
            S_RAS: begin
                pins_n.shap_n = ~addr_s[7:0];
                pins_n.ras_n  = 1'b0;
            end
            S_COL_SETUP: begin
                pins_n.shap_n = ~addr_s[15:8];
                pins_n.ras_n  = 1'b0;
            end
            S_CAS: begin
                pins_n.shap_n = ~addr_s[15:8];
                pins_n.ras_n  = 1'b0;
                pins_n.cas_n  = 1'b0;
            end
            S_IOADDR: pins_n.shavv_n = ~addr_s[7:0];
            S_STROBE: begin
                if (op_s[1]) begin
                    pins_n.shavv_n = ~addr_s[7:0];
                    pins_n.iord_n  = op_s[0];
                    pins_n.iowr_n  = ~op_s[0];
                end else begin
                    pins_n.shap_n  = ~addr_s[15:8];
                    pins_n.ras_n   = 1'b0;
                    pins_n.cas_n   = 1'b0;
                    pins_n.memrd_n = op_s[0];
                    pins_n.memwr_n = ~op_s[0];
                end
                if (op_s[0]) begin
                    pins_n.shd_oe = 1'b1;
                    pins_n.shd_o  = wdata_s;
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_cpu or posedge sys_reset) begin
        if (sys_reset) begin
            state     <= S_IDLE;
            cnt       <= 8'd0;
            pins      <= PINS_IDLE;
            op_q      <= 2'b00;
            addr_q    <= 16'h0000;
            wdata_q   <= 8'h00;
            stack_q   <= 1'b0;
            rdata     <= 8'h00;
            responded <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            pins  <= pins_n;
            if (state == S_IDLE && req) begin
                op_q    <= op;
                addr_q  <= addr;
                wdata_q <= wdata;
                stack_q <= stack;
            end
            if (state == S_STROBE && cnt == 8'd0) begin
                responded <= ~vu_blk_n;
                if (!op_q[0]) rdata <= vu_blk_n ? 8'hFF : vu_shd_i;
            end
        end
    end

    assign busy          = pins.busy;
    assign done          = pins.done;
    assign vu_shap_n     = pins.shap_n;
    assign vu_shavv_n    = pins.shavv_n;
    assign vu_ras_n      = pins.ras_n;
    assign vu_cas_n      = pins.cas_n;
    assign vu_memrd_n    = pins.memrd_n;
    assign vu_memwr_n    = pins.memwr_n;
    assign vu_iord_n     = pins.iord_n;
    assign vu_iowr_n     = pins.iowr_n;
    assign vu_strob_sost = pins.strob_sost;
    assign vu_shd_o      = pins.shd_o;
    assign vu_shd_oe     = pins.shd_oe;

endmodule

// File: tb/tb_vu_bus_master.sv
// Scoreboard bench for vu_bus_master: directed requests push expected cycle
// summaries; a monitor observes the bus pins and compares on each done pulse.
module tb_vu_bus_master;

    logic        clk_cpu = 1'b0;
    logic        sys_reset = 1'b1;
    logic        req = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  wdata = 8'h00;
    logic        stack = 1'b0;
    logic        busy, done, responded;
    logic [7:0]  rdata, vu_shap_n, vu_shavv_n, vu_shd_o, vu_shd_i;
    logic        vu_ras_n, vu_cas_n, vu_memrd_n, vu_memwr_n, vu_iord_n, vu_iowr_n;
    logic        vu_strob_sost, vu_shd_oe, vu_blk_n;

    logic        resp_en = 1'b0;
    logic [7:0]  resp_data = 8'h00;

    int n_checks = 0;
    int n_pass   = 0;

    vu_bus_master dut (
        .clk_cpu(clk_cpu), .sys_reset(sys_reset), .req(req), .op(op), .addr(addr),
        .wdata(wdata), .stack(stack), .busy(busy), .done(done), .rdata(rdata),
        .responded(responded), .vu_shap_n(vu_shap_n), .vu_shavv_n(vu_shavv_n),
        .vu_ras_n(vu_ras_n), .vu_cas_n(vu_cas_n), .vu_memrd_n(vu_memrd_n),
        .vu_memwr_n(vu_memwr_n), .vu_iord_n(vu_iord_n), .vu_iowr_n(vu_iowr_n),
        .vu_strob_sost(vu_strob_sost), .vu_shd_o(vu_shd_o), .vu_shd_oe(vu_shd_oe),
        .vu_shd_i(vu_shd_i), .vu_blk_n(vu_blk_n)
    );

    always #5 clk_cpu = ~clk_cpu;

    // Loopback responder: claims any strobe when enabled, drives data on reads.
    always_comb begin
        vu_blk_n = 1'b1;
        vu_shd_i = 8'hFF;
        if (resp_en && !(vu_memrd_n && vu_memwr_n && vu_iord_n && vu_iowr_n)) vu_blk_n = 1'b0;
        if (resp_en && !(vu_memrd_n && vu_iord_n)) vu_shd_i = resp_data;
    end

    typedef struct {
        string      name;
        logic [7:0] status, row, col, shavv, wr_data, rdata;
        logic       responded;
        int         stb_len, ras_cnt, oe_cnt, len;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: accumulates what the bus did during one cycle, compares at done.
    exp_t obs;
    logic prev_ras = 1'b1, prev_cas = 1'b1;

    function automatic exp_t blank_obs();
        exp_t o;
        o.name = ""; o.status = 8'h00; o.row = 8'hFF; o.col = 8'hFF; o.shavv = 8'hFF;
        o.wr_data = 8'h00; o.rdata = 8'h00; o.responded = 1'b0;
        o.stb_len = 0; o.ras_cnt = 0; o.oe_cnt = 0; o.len = 0;
        return o;
    endfunction

    initial obs = blank_obs();

    always @(negedge clk_cpu) begin
        if (sys_reset || !busy) begin
            obs = blank_obs();
        end else begin
            obs.len++;
            if (vu_strob_sost) obs.status = vu_shd_o;
            if (!vu_ras_n && prev_ras) obs.row = vu_shap_n;
            if (!vu_cas_n && prev_cas) obs.col = vu_shap_n;
            if (!vu_ras_n) obs.ras_cnt++;
            if (!vu_iord_n || !vu_iowr_n) obs.shavv = vu_shavv_n;
            if (!(vu_memrd_n && vu_memwr_n && vu_iord_n && vu_iowr_n)) begin
                obs.stb_len++;
                if (vu_shd_oe) begin
                    obs.oe_cnt++;
                    obs.wr_data = vu_shd_o;
                end
            end
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.name, "_status"},    obs.status,    e.status);
                    check({e.name, "_row"},       obs.row,       e.row);
                    check({e.name, "_col"},       obs.col,       e.col);
                    check({e.name, "_shavv"},     obs.shavv,     e.shavv);
                    check({e.name, "_strobe"},    obs.stb_len,   e.stb_len);
                    check({e.name, "_ras_low"},   obs.ras_cnt,   e.ras_cnt);
                    check({e.name, "_oe_strobe"}, obs.oe_cnt,    e.oe_cnt);
                    check({e.name, "_wr_data"},   obs.wr_data,   e.wr_data);
                    check({e.name, "_rdata"},     rdata,         e.rdata);
                    check({e.name, "_responded"}, responded,     e.responded);
                    check({e.name, "_length"},    obs.len,       e.len);
                end
            end
        end
        prev_ras = vu_ras_n;
        prev_cas = vu_cas_n;
    end

    task automatic issue(input logic [1:0] o, input logic [15:0] a, input logic [7:0] d,
                         input logic s, input bit push, input exp_t e);
        @(negedge clk_cpu);
        op = o; addr = a; wdata = d; stack = s; req = 1'b1;
        if (push) sb.push_back(e);
        @(posedge clk_cpu);
        #1 req = 1'b0;
        check({e.name, "_accept"}, busy, 1'b1);
    endtask

    task automatic wait_done(input string name);
        int n;
        for (n = 0; n < 60; n++) begin
            @(negedge clk_cpu);
            if (done) break;
        end
        if (n == 60) begin
            n_checks++;
            $display("FAIL %s_timeout: no done within 60 cycles", name);
        end
    endtask

    function automatic exp_t mk(input string name, input logic [7:0] status, row, col,
                                shavv, wr_data, rd, input logic resp, input int ras_cnt,
                                oe_cnt, len);
        exp_t e;
        e.name = name; e.status = status; e.row = row; e.col = col; e.shavv = shavv;
        e.wr_data = wr_data; e.rdata = rd; e.responded = resp; e.stb_len = 4;
        e.ras_cnt = ras_cnt; e.oe_cnt = oe_cnt; e.len = len;
        return e;
    endfunction

    initial begin
        int n;
        // Reset values while reset is held.
        repeat (2) @(negedge clk_cpu);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rdata", rdata, 8'h00);
        check("rst_responded", responded, 1'b0);
        check("rst_shap", {vu_shap_n, vu_shavv_n}, 16'hFFFF);
        check("rst_strobes", {vu_ras_n, vu_cas_n, vu_memrd_n, vu_memwr_n, vu_iord_n, vu_iowr_n}, 6'h3F);
        check("rst_bus", {vu_strob_sost, vu_shd_oe, vu_shd_o}, 10'h000);
        sys_reset = 1'b0;

        // Reset mid-cycle during RAS of a memrd.
        issue(2'b00, 16'h1234, 8'h00, 1'b0, 1'b0, mk("abort", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (n = 0; n < 30; n++) begin
            @(negedge clk_cpu);
            if (!vu_ras_n) break;
        end
        check("abort_ras_seen", vu_ras_n, 1'b0);
        #2 sys_reset = 1'b1;
        #1;
        check("abort_ras_n", vu_ras_n, 1'b1);
        check("abort_shap", vu_shap_n, 8'hFF);
        check("abort_busy", busy, 1'b0);
        @(negedge clk_cpu);
        @(negedge clk_cpu);
        sys_reset = 1'b0;

        // Memory read with loopback responder.
        resp_en = 1'b1; resp_data = 8'hA5;
        issue(2'b00, 16'h1234, 8'h00, 1'b0, 1'b1,
              mk("memrd", 8'h82, 8'hCB, 8'hED, 8'hFF, 8'h00, 8'hA5, 1'b1, 9, 0, 16));
        wait_done("memrd");

        // Memory write with STACK; rdata must keep A5.
        issue(2'b01, 16'h8001, 8'h3C, 1'b1, 1'b1,
              mk("memwr", 8'h04, 8'hFE, 8'h7F, 8'hFF, 8'h3C, 8'hA5, 1'b1, 9, 4, 16));
        wait_done("memwr");

        // I/O read with nobody answering.
        resp_en = 1'b0;
        issue(2'b10, 16'h0018, 8'h00, 1'b0, 1'b1,
              mk("iord", 8'h42, 8'hFF, 8'hFF, 8'hE7, 8'h00, 8'hFF, 1'b0, 0, 0, 11));
        wait_done("iord");

        // I/O write; a req pulsed while busy must be dropped.
        issue(2'b11, 16'h0010, 8'h20, 1'b0, 1'b1,
              mk("iowr", 8'h10, 8'hFF, 8'hFF, 8'hEF, 8'h20, 8'hFF, 1'b0, 0, 4, 11));
        repeat (3) @(negedge clk_cpu);
        op = 2'b00; addr = 16'h5555; req = 1'b1;
        @(negedge clk_cpu);
        req = 1'b0;
        wait_done("iowr");

        // Back-to-back: request in the idle cycle right after done.
        resp_en = 1'b1; resp_data = 8'h5A;
        issue(2'b00, 16'h00FF, 8'h00, 1'b0, 1'b1,
              mk("b2b", 8'h82, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h5A, 1'b1, 9, 0, 16));
        wait_done("b2b");

        repeat (6) @(negedge clk_cpu);
        check("final_idle", busy, 1'b0);
        check("final_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
